// File: rtl/dsram_evict.sv
// dsram_evict: victim-line reader for the per-way dsram arrays.
// Reads one 256-bit line from the selected way, holds it in a line buffer and
// streams it to the memory write port as BEATS beats over valid/ready.
module dsram_evict #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAYS       = 4,
  parameter int WAY_BITS   = 2,
  parameter int TAG_WIDTH  = 14,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_index,
  input  logic [WAY_BITS-1:0]             req_way,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  output logic [ADDR_WIDTH-1:0]           ds_a,
  output logic                            ds_read,
  output logic [WAYS-1:0]                 ds_way_sel,
  input  logic [255:0]                    ds_rd,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [TAG_WIDTH+ADDR_WIDTH+4:0] mem_addr,
  output logic [BEAT_WIDTH-1:0]           mem_data,
  output logic                            mem_last,
  output logic                            busy,
  output logic                            done
);

  localparam int BEATS = 256 / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           idx_q;
  logic [WAY_BITS-1:0]             way_q;
  logic [TAG_WIDTH-1:0]            tag_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            done_q;
  logic [BEAT_WIDTH-1:0]           beat_data;
  logic                            accept;
  logic                            beat_fire;
  logic                            last_beat;

  assign accept    = (state_q == IDLE) && req_valid;
  assign beat_fire = (state_q == SEND) && mem_ready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> RD -> CAP -> SEND -> IDLE.
  always_comb begin
    // NOTE: default first so no path through the block leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = RD;
      RD:   state_d = CAP;
      CAP:  state_d = SEND;
      SEND: if (mem_ready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the victim descriptor on accept; untouched for the rest of the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      way_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      idx_q <= req_index;
      way_q <= req_way;
      tag_q <= req_tag;
    end
  end

  // Capture the registered dsram read data at the end of CAP.
  always_ff @(posedge clk) begin
    // NOTE: the line buffer has no reset; it is always overwritten in CAP
    // before it is read, and outputs are gated to 0 outside SEND.
    if (state_q == CAP) line_q <= ds_rd;
  end

  // Beat counter and the done pulse that follows the last handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= beat_fire && last_beat;
      if (state_q == CAP)  cnt_q <= '0;
      else if (beat_fire)  cnt_q <= cnt_q + 1'b1;
    end
  end

  // Beat select; a single-beat build always presents the whole line.
  if (BEATS == 1) begin : g_one_beat
    assign beat_data = line_q[0];
  end else begin : g_multi_beat
    assign beat_data = line_q[cnt_q];
  end

  // Output decode; everything except req_ready idles at 0.
  always_comb begin
    req_ready  = 1'b0;
    ds_a       = '0;
    ds_read    = 1'b0;
    ds_way_sel = '0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_last   = 1'b0;
    busy       = (state_q != IDLE);
    done       = done_q;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      RD, CAP: begin
        ds_a       = idx_q;
        ds_read    = 1'b1;
        ds_way_sel = WAYS'(1) << way_q;
      end
      SEND: begin
        mem_valid = 1'b1;
        mem_addr  = {tag_q, idx_q, 5'b0};
        mem_data  = beat_data;
        mem_last  = last_beat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dsram_evict.sv
// tb_dsram_evict: scoreboard bench for dsram_evict (64-bit beats) plus a
// second 256-bit-beat instance for the single-beat build.
module tb_dsram_evict;

  localparam int AW = 13, WAYS = 4, WB = 2, TW = 14, BW = 64, BEATS = 4;
  localparam int MAW = TW + AW + 5;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  // 64-bit-beat instance signals
  logic            req_valid = 0, req_ready;
  logic [AW-1:0]   req_index = '0;
  logic [WB-1:0]   req_way = '0;
  logic [TW-1:0]   req_tag = '0;
  logic [AW-1:0]   ds_a;
  logic            ds_read;
  logic [WAYS-1:0] ds_way_sel;
  logic [255:0]    ds_rd;
  logic            mem_valid, mem_ready = 1, mem_last, busy, done;
  logic [MAW-1:0]  mem_addr;
  logic [BW-1:0]   mem_data;

  // 256-bit-beat instance signals
  logic            req_valid_w = 0, req_ready_w;
  logic [AW-1:0]   req_index_w = '0;
  logic [WB-1:0]   req_way_w = '0;
  logic [TW-1:0]   req_tag_w = '0;
  logic [AW-1:0]   ds_a_w;
  logic            ds_read_w;
  logic [WAYS-1:0] ds_way_sel_w;
  logic [255:0]    ds_rd_w;
  logic            mem_valid_w, mem_ready_w = 1, mem_last_w, busy_w, done_w;
  logic [MAW-1:0]  mem_addr_w;
  logic [255:0]    mem_data_w;

  dsram_evict #(.ADDR_WIDTH(AW), .WAYS(WAYS), .WAY_BITS(WB), .TAG_WIDTH(TW), .BEAT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_way(req_way), .req_tag(req_tag),
    .ds_a(ds_a), .ds_read(ds_read), .ds_way_sel(ds_way_sel), .ds_rd(ds_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_last(mem_last), .busy(busy), .done(done));

  dsram_evict #(.ADDR_WIDTH(AW), .WAYS(WAYS), .WAY_BITS(WB), .TAG_WIDTH(TW), .BEAT_WIDTH(256)) dut_w (
    .clk(clk), .reset(reset), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_index(req_index_w), .req_way(req_way_w), .req_tag(req_tag_w),
    .ds_a(ds_a_w), .ds_read(ds_read_w), .ds_way_sel(ds_way_sel_w), .ds_rd(ds_rd_w),
    .mem_valid(mem_valid_w), .mem_ready(mem_ready_w), .mem_addr(mem_addr_w),
    .mem_data(mem_data_w), .mem_last(mem_last_w), .busy(busy_w), .done(done_w));

  // Line contents: way 2 / index 0x005 holds bytes 0x00..0x1F; others are perturbed.
  function automatic logic [255:0] line_of(input logic [WB-1:0] way, input logic [AW-1:0] idx);
    logic [255:0] l;
    logic [7:0]   mask;
    mask = {idx[4:0] ^ 5'd5, 1'b0, way ^ 2'd2};
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = 8'(i) ^ mask;
    return l;
  endfunction

  // Behavioural dsram ways: registered read, output muxed by way select.
  logic [255:0] rd_q [WAYS];
  logic [255:0] rd_q_w [WAYS];
  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (ds_read && ds_way_sel[w])     rd_q[w]   <= line_of(WB'(w), ds_a);
      if (ds_read_w && ds_way_sel_w[w]) rd_q_w[w] <= line_of(WB'(w), ds_a_w);
    end
  end
  always_comb begin
    ds_rd   = '0;
    ds_rd_w = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ds_way_sel[w])   ds_rd   = rd_q[w];
      if (ds_way_sel_w[w]) ds_rd_w = rd_q_w[w];
    end
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0]  data;
    logic [MAW-1:0] addr;
    logic           last;
  } beat_t;

  beat_t          sb[$];
  logic           done_exp = 0;
  logic           need_rd = 0, need_vld = 0;
  int             acc_cyc = 0;
  logic [WB-1:0]  cur_way = '0;
  logic [AW-1:0]  cur_idx = '0;

  // Monitor: push expected beats on accept, compare/pop on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("done", done, done_exp);
        done_exp = 1'b0;
        if (req_valid && req_ready) begin
          logic [255:0] l;
          l = line_of(req_way, req_index);
          for (int b = 0; b < BEATS; b++) begin
            beat_t e;
            e.data = l[b*BW +: BW];
            e.addr = {req_tag, req_index, 5'b0};
            e.last = (b == BEATS - 1);
            sb.push_back(e);
          end
          acc_cyc  = cyc;
          need_rd  = 1'b1;
          need_vld = 1'b1;
          cur_way  = req_way;
          cur_idx  = req_index;
        end
        if (ds_read) begin
          check("ds_way_sel", ds_way_sel, WAYS'(1) << cur_way);
          check("ds_a", ds_a, cur_idx);
          if (need_rd) begin
            check("rd_latency", cyc - acc_cyc, 1);
            need_rd = 1'b0;
          end
        end
        if (mem_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            if (need_vld) begin
              check("valid_latency", cyc - acc_cyc, 3);
              need_vld = 1'b0;
            end
            check("mem_data", mem_data, sb[0].data);
            check("mem_addr", mem_addr, sb[0].addr);
            check("mem_last", mem_last, sb[0].last);
            if (mem_ready) begin
              done_exp = sb[0].last;
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic send_req(input logic [AW-1:0] idx, input logic [WB-1:0] way, input logic [TW-1:0] tag);
    bit got = 0;
    @(posedge clk); #1;
    req_valid = 1; req_index = idx; req_way = way; req_tag = tag;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (mem_valid) got = 1;
    end
    if (!got) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) got = 1;
    end
    if (!got) check("drain_timeout", 0, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    // T1a: reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs", {ds_read, ds_way_sel, mem_valid, mem_last, busy, done}, 0);
    check("rst_ds_a", ds_a, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_w_outputs", {req_ready_w, mem_valid_w, mem_last_w, busy_w, done_w}, 5'b10000);
    @(posedge clk); #1 reset = 0;

    // T2: basic evict, way 2 index 0x005 tag 0x0A5
    send_req(13'h005, 2'd2, 14'h0A5);
    wait_valid();
    check("t2_beat0", mem_data, 64'h0706050403020100);
    check("t2_addr", mem_addr, 32'h0294_00A0);
    wait_drain();

    // T3: beat 1 stalled for 5 cycles
    mem_ready = 0;
    send_req(13'h0123, 2'd1, 14'h1234);
    wait_valid();
    @(posedge clk); #1 mem_ready = 1;
    @(posedge clk); #1 mem_ready = 0;
    repeat (5) @(posedge clk);
    #1 mem_ready = 1;
    wait_drain();

    // T4: back-to-back, second request held through first burst
    @(posedge clk); #1;
    req_valid = 1; req_index = 13'h1F00; req_way = 2'd3; req_tag = 14'h2AAA;
    @(negedge clk);
    check("t4_first_accept", req_ready, 1);
    @(posedge clk); #1;
    req_index = 13'h0042; req_way = 2'd0; req_tag = 14'h0555;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req_ready) begin
          got = 1;
          check("t4_accept_in_done_cycle", done, 1);
        end
      end
      if (!got) check("t4_accept_timeout", 0, 1);
    end
    @(posedge clk); #1 req_valid = 0;
    wait_drain();

    // T5: request inputs churn while a burst is in flight
    send_req(13'h0AAA, 2'd2, 14'h3C3C);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_index = AW'($urandom); req_way = WB'($urandom); req_tag = TW'($urandom);
    end
    wait_drain();

    // T1b: reset mid-SEND drops the burst asynchronously
    send_req(13'h0777, 2'd1, 14'h0F0F);
    wait_valid();
    @(posedge clk); #2 reset = 1;
    #1;
    check("t1_mem_valid", mem_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_req_ready", req_ready, 1);
    sb.delete();
    done_exp = 0; need_rd = 0; need_vld = 0;
    @(posedge clk); #1 reset = 0;
    repeat (3) @(negedge clk);
    check("t1_no_done", done, 0);

    // T6: 256-bit beat instance, single beat equals the full line
    @(posedge clk); #1;
    req_valid_w = 1; req_index_w = 13'h1AB; req_way_w = 2'd1; req_tag_w = 14'h3FFF;
    @(negedge clk);
    check("t6_accept", req_ready_w, 1);
    @(posedge clk); #1 req_valid_w = 0;
    begin
      int n = 1;
      bit got = 0;
      while (n < 20 && !got) begin
        @(negedge clk);
        n++;
        if (mem_valid_w) got = 1;
      end
      if (!got) check("t6_valid_timeout", 0, 1);
      check("t6_latency", n - 1, 3);
    end
    check("t6_data", mem_data_w, line_of(2'd1, 13'h1AB));
    check("t6_last", mem_last_w, 1);
    check("t6_addr", mem_addr_w, {14'h3FFF, 13'h1AB, 5'b0});
    @(negedge clk);
    check("t6_done", done_w, 1);
    check("t6_valid_drop", mem_valid_w, 0);
    @(negedge clk);
    check("t6_done_pulse", done_w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
